lock_sequencer: RTL
===================

# lock_sequencer

Sequencing controller for the password-lock datapath. It assembles four keypad nibbles into the 16-bit candidate word and strobes the combinational password comparator for exactly one cycle. It then sequences the resulting unlock window, counts consecutive failures and enforces a timed lockout after too many failures. It sits between the keypad decoder and the password-check/error-processing pair, and drives their `pw_16bit` and `enb_cmp` inputs.

## Interface
- `MAX_FAIL`, 3: consecutive failed compares that trigger lockout (≥1).
- `UNLOCK_CYCLES`, 50_000_000: cycles `unlock` stays high after a match (≥1).
- `LOCKOUT_CYCLES`, 500_000_000: cycles of lockout (≥1).
- `ENTRY_TIMEOUT`, 250_000_000: idle cycles in ENTRY before the buffer is discarded (≥1).
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  one-cycle strobe, `key_code` valid.
- `key_code`  in  4  hex digit.
- `key_enter`  in  1  one-cycle strobe, submit entry.
- `key_clear`  in  1  one-cycle strobe, discard entry / relock.
- `match`  in  1  comparator result; only sampled while `enb_cmp`=1.
- `pw_16bit`  out  16  candidate word to the comparator.
- `enb_cmp`  out  1  compare strobe.
- `unlock`  out  1  lock actuator enable.
- `lockout`  out  1  lockout active.
- `fail_pulse`  out  1  one-cycle pulse per failed compare.
- `digit_cnt`  out  3  digits entered (0..4).
- `fail_cnt`  out  2+  consecutive failures, width `$clog2(MAX_FAIL+1)`.

## Operation
- States: IDLE, ENTRY, CMP, UNLOCK, FAIL, LOCKOUT.
- Priority among same-cycle strobes: `key_clear` > `key_enter` > `key_valid`.
- IDLE/ENTRY, `key_valid`:
  - If `digit_cnt`<4: `pw_16bit` ← {`pw_16bit`[11:0], `key_code`}, `digit_cnt`++.
  - At 4 the digit is ignored (saturates).
  - IDLE moves to ENTRY.
- ENTRY, `key_enter` with `digit_cnt`==4 → CMP.
- ENTRY, `key_enter` with `digit_cnt`<4 → FAIL (counts as a failure, no compare).
- `key_enter` in IDLE is ignored.
- `key_clear` in IDLE/ENTRY → clear `pw_16bit`/`digit_cnt`, go to IDLE; `fail_cnt` unchanged.
- ENTRY timeout: the timer reloads on every accepted key. Expiry → clear the buffer, IDLE, no failure counted.
- CMP, one cycle, `enb_cmp`=1:
  - `match`=1 → UNLOCK, `fail_cnt`←0.
  - Otherwise → FAIL.
  - `pw_16bit` and `digit_cnt` clear on exit in both cases.
- FAIL, one cycle, `fail_pulse`=1, `fail_cnt`++:
  - If the new count == `MAX_FAIL` → LOCKOUT.
  - Else → IDLE.
- UNLOCK: `unlock`=1 for `UNLOCK_CYCLES` cycles, then IDLE. `key_clear` ends it early (→ IDLE next cycle). Other keys are ignored.
- LOCKOUT: `lockout`=1 for `LOCKOUT_CYCLES` cycles; all keys ignored. On exit: `fail_cnt`←0, go to IDLE.
- Reset (any time, including mid-UNLOCK or mid-LOCKOUT): state IDLE, all outputs 0, counters 0, timer 0.

## Timing
- All outputs are registered or decoded from the state register; no combinational input→output path.
- `key_valid` at edge N → `pw_16bit`/`digit_cnt` updated after edge N.
- `key_enter` sampled at edge N → `enb_cmp` high in cycle N+1 for exactly one cycle. `match` is sampled at edge N+2.
- Match: `unlock` rises in cycle N+2 and stays high exactly `UNLOCK_CYCLES` cycles.
- Mismatch: `fail_pulse` in cycle N+2. If lockout is reached, `lockout` rises in cycle N+3 and stays high exactly `LOCKOUT_CYCLES` cycles.
- ENTRY timeout fires exactly `ENTRY_TIMEOUT` cycles after the last accepted key.
- `enb_cmp`, `unlock`, `lockout` and `fail_pulse` are mutually exclusive.

## Structure
- Package `lock_pkg`:
  - state enum;
  - `PW_W`=16, `DIGIT_W`=4, `DIGITS`=4;
  - timer width, derived as `$clog2` of the largest cycle parameter.
- One natural sub-module, `lock_timer`: a loadable down-counter with `load`, `load_val`, `expired`. A single instance is shared by the ENTRY, UNLOCK and LOCKOUT states; it is reloaded on each state entry.

## Test plan
Bench parameters: `MAX_FAIL`=3, `UNLOCK_CYCLES`=8, `LOCKOUT_CYCLES`=16, `ENTRY_TIMEOUT`=32; comparator password 16'h1234.

- Keys 1,2,3,4 then enter → `pw_16bit`=16'h1234 with a 1-cycle `enb_cmp`; `unlock` high exactly 8 cycles; `fail_cnt`=0.
- Keys 1,2,3,5, enter, three times → `fail_pulse` 3×, `fail_cnt` 1,2,3; `lockout` high 16 cycles, keys ignored during it; afterwards `fail_cnt`=0 and 1,2,3,4 unlocks.
- Keys 1,2 then enter → FAIL, no `enb_cmp`, `fail_cnt`=1. Keys 1,2,3,4,9 → `pw_16bit`=16'h1234 and `digit_cnt`=4 (5th ignored).
- Key 7 then 32 idle cycles → buffer 0, state IDLE, `fail_cnt` unchanged. `key_clear` with `key_enter` in the same cycle → clear wins, no compare.
- `key_clear` on the 3rd cycle of `unlock` → `unlock` low next cycle.
- `reset` asserted mid-LOCKOUT between edges → all outputs 0 immediately; the next 1,2,3,4 unlocks.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding, datapath widths and timer sizing for the lock sequencer
package lock_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, CMP, UNLOCK, FAIL, LOCKOUT} state_t;
  localparam int PW_W = 16;
  localparam int DIGIT_W = 4;
  localparam int DIGITS = 4;
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 1 ? $clog2(m) : 1;
  endfunction
  localparam int TIMER_W = timer_width(50_000_000, 500_000_000, 250_000_000);
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter, expired while the count sits at zero
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad entry assembly, compare strobe, unlock window and failure lockout
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int MAX_FAIL       = 3,
  parameter int UNLOCK_CYCLES  = 50_000_000,
  parameter int LOCKOUT_CYCLES = 500_000_000,
  parameter int ENTRY_TIMEOUT  = 250_000_000
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               key_valid,
  input  logic [DIGIT_W-1:0]                 key_code,
  input  logic                               key_enter,
  input  logic                               key_clear,
  input  logic                               match,
  output logic [PW_W-1:0]                    pw_16bit,
  output logic                               enb_cmp,
  output logic                               unlock,
  output logic                               lockout,
  output logic                               fail_pulse,
  output logic [2:0]                         digit_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT);
  state_t state, state_n;
  logic [PW_W-1:0] pw_n;
  logic [2:0] dc_n;
  logic [FW-1:0] fc_n;
  logic load, expired;
  logic [TW-1:0] load_val;
  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );
  always_comb begin
    state_n  = state;
    pw_n     = pw_16bit;
    dc_n     = digit_cnt;
    fc_n     = fail_cnt;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE, ENTRY: begin
        if (key_clear) begin
          state_n = IDLE;
          pw_n    = '0;
          dc_n    = '0;
        end else if (key_enter && state == ENTRY) begin
          state_n = digit_cnt == 3'(DIGITS) ? CMP : FAIL;
          pw_n    = digit_cnt == 3'(DIGITS) ? pw_16bit : '0;
          dc_n    = digit_cnt == 3'(DIGITS) ? digit_cnt : '0;
        end else if (key_valid && digit_cnt < 3'(DIGITS)) begin
          state_n  = ENTRY;
          pw_n     = {pw_16bit[PW_W-DIGIT_W-1:0], key_code};
          dc_n     = digit_cnt + 1'b1;
          load     = 1'b1;
          load_val = TW'(ENTRY_TIMEOUT - 1);
        end else if (state == ENTRY && expired) begin
          state_n = IDLE;
          pw_n    = '0;
          dc_n    = '0;
        end
      end
      CMP: begin
        pw_n     = '0;
        dc_n     = '0;
        state_n  = match ? UNLOCK : FAIL;
        fc_n     = match ? '0 : fail_cnt;
        load     = match;
        load_val = TW'(UNLOCK_CYCLES - 1);
      end
      FAIL: begin
        fc_n     = fail_cnt + 1'b1;
        state_n  = fc_n == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
        load     = fc_n == FW'(MAX_FAIL);
        load_val = TW'(LOCKOUT_CYCLES - 1);
      end
      UNLOCK: state_n = key_clear || expired ? IDLE : UNLOCK;
      LOCKOUT: begin
        state_n = expired ? IDLE : LOCKOUT;
        fc_n    = expired ? '0 : fail_cnt;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      pw_16bit  <= '0;
      digit_cnt <= '0;
      fail_cnt  <= '0;
    end else begin
      state     <= state_n;
      pw_16bit  <= pw_n;
      digit_cnt <= dc_n;
      fail_cnt  <= fc_n;
    end
  assign enb_cmp    = state == CMP;
  assign unlock     = state == UNLOCK;
  assign lockout    = state == LOCKOUT;
  assign fail_pulse = state == FAIL;
endmodule
